// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
// Round-robin share of one combinational ALU between two requesters; optional ALU_SHARE_DIV0_EN short-circuits divide-by-zero.
// Latency: handshake to rsp_valid = lat(op)+1 cycles (1 cycle for a short-circuited divide-by-zero).
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready of the granted port.
module alu_share_arbiter #(
    parameter int N          = 20,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    input  logic [5:0]     req_op,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [N-1:0]   rsp_result,
    output logic           rsp_z,
    output logic           rsp_err,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [2:0]     alu_opcode,
    input  logic [N-1:0]   alu_result,
    input  logic           alu_z,
    output logic           busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int MAXLAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    logic [1:0]    state;
    logic          last_grant;
    logic          gnt;
    logic [CW-1:0] count;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [2:0]    op_code;
    logic [N-1:0]  res_q;
    logic          z_q;

    logic          idle_g;
    logic          hs;
    logic [N-1:0]  sel_a;
    logic [N-1:0]  sel_b;
    logic [2:0]    sel_op;
    logic [CW-1:0] lat_ld;

    // With both requesting, the port that was not served last wins.
    always_comb begin
        idle_g = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        hs     = (state == IDLE) && (req_valid != 2'b00);
        sel_a  = idle_g ? req_a[N +: N] : req_a[0 +: N];
        sel_b  = idle_g ? req_b[N +: N] : req_b[0 +: N];
        sel_op = idle_g ? req_op[3 +: 3] : req_op[0 +: 3];
        case (sel_op)
            3'b010:  lat_ld = CW'(MUL_CYCLES - 1);
            3'b011:  lat_ld = CW'(DIV_CYCLES - 1);
            default: lat_ld = '0;
        endcase
    end

    assign req_ready  = hs ? (idle_g ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid  = (state == RESP) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (state != IDLE);
    assign rsp_result = res_q;
    assign rsp_z      = z_q;

    // Operands reach the ALU only while executing so MUL/DIV can be multicycle paths.
    assign alu_a      = (state == EXEC) ? op_a    : '0;
    assign alu_b      = (state == EXEC) ? op_b    : '0;
    assign alu_opcode = (state == EXEC) ? op_code : 3'b000;

`ifdef ALU_SHARE_DIV0_EN
    logic err_q;
    logic div0;
    assign div0    = (sel_op == 3'b011) && (sel_b == '0);
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            count      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= 3'b000;
            res_q      <= '0;
            z_q        <= 1'b0;
`ifdef ALU_SHARE_DIV0_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        gnt     <= idle_g;
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_code <= sel_op;
                        count   <= lat_ld;
                        state   <= EXEC;
`ifdef ALU_SHARE_DIV0_EN
                        if (div0) begin
                            res_q <= '1;
                            z_q   <= 1'b0;
                            err_q <= 1'b1;
                            state <= RESP;
                        end
`endif
                    end
                end
                EXEC: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        res_q <= alu_result;
                        z_q   <= alu_z;
`ifdef ALU_SHARE_DIV0_EN
                        err_q <= 1'b0;
`endif
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt]) begin
                        last_grant <= gnt;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;

    localparam int N    = 20;
    localparam int MULC = 2;
    localparam int DIVC = 4;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;
    localparam logic [N-1:0] ALU_DIV0_VAL = 20'h0ABCD;
`ifdef ALU_SHARE_DIV0_EN
    localparam bit DIV0_EN = 1'b1;
`else
    localparam bit DIV0_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid, req_ready, rsp_valid;
    logic [1:0]     rsp_ready = 2'b11;
    logic [2*N-1:0] req_a, req_b;
    logic [5:0]     req_op;
    logic [N-1:0]   rsp_result, alu_a, alu_b, alu_result;
    logic           rsp_z, rsp_err, alu_z, busy;
    logic [2:0]     alu_opcode;

    logic [N-1:0]   a_d[2];
    logic [N-1:0]   b_d[2];
    logic [2:0]     op_d[2];
    logic           v_d[2];
    int             drv_tmo[2];
    int             idle_tmo = 0;
    logic           rr_force = 1'b1;
    logic [1:0]     rr_val = 2'b11;
    logic           done = 1'b0;

    always #5 clk = ~clk;

    assign req_valid = {v_d[1], v_d[0]};
    assign req_a     = {a_d[1], a_d[0]};
    assign req_b     = {b_d[1], b_d[0]};
    assign req_op    = {op_d[1], op_d[0]};

    // Behavioural ALU: N-bit wrap/truncate; divide by zero yields a recognisable constant.
    function automatic logic [N-1:0] alu_f(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == '0) ? ALU_DIV0_VAL : a / b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SHL:  return a << b;
            default: return a >> b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        if (op == OP_MUL) return MULC;
        if (op == OP_DIV) return DIVC;
        return 1;
    endfunction

    assign alu_result = alu_f(alu_opcode, alu_a, alu_b);
    assign alu_z      = (alu_result == '0);

    alu_share_arbiter #(.N(N), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_z(alu_z), .busy(busy)
    );

    // Response-ready driver: forced value or random per port.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = rr_force ? rr_val
                                 : {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int           port;
        logic [2:0]   op;
        logic [N-1:0] a, b, res;
        logic         z, err, div0;
        int           lat, hs;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_vec = 0, n_err = 0, cyc = 0, exec_n = 0;
    logic       last_srv = 1'b1;
    logic       in_rsp = 1'b0;
    logic [1:0] exp_rdy;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (cyc > 50000) begin
            $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
            $fatal(1, "bench watchdog");
        end
        if (!rst_n) begin
            chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_z, rsp_err,
                                  alu_a, alu_b, alu_opcode, busy}, 80'd0);
            exp_q.delete();
            last_srv = 1'b1;
            in_rsp   = 1'b0;
            exec_n   = 0;
        end else begin
            if (busy) begin
                chk("ready_while_busy", req_ready, 2'b00);
            end else begin
                if (req_valid == 2'b11) exp_rdy = last_srv ? 2'b01 : 2'b10;
                else                    exp_rdy = req_valid;
                chk("ready_idle", req_ready, exp_rdy);
                for (int p = 0; p < 2; p++) begin
                    if (req_valid[p] && req_ready[p]) begin
                        e.port = p;
                        e.op   = req_op[p*3 +: 3];
                        e.a    = req_a[p*N +: N];
                        e.b    = req_b[p*N +: N];
                        e.lat  = lat_of(e.op);
                        e.div0 = DIV0_EN && (e.op == OP_DIV) && (e.b == '0);
                        e.res  = e.div0 ? '1 : alu_f(e.op, e.a, e.b);
                        e.z    = e.div0 ? 1'b0 : (e.res == '0);
                        e.err  = e.div0;
                        e.hs   = cyc;
                        exp_q.push_back(e);
                    end
                end
            end

            if (rsp_valid != 2'b00) begin
                chk("busy_in_resp", busy, 1'b1);
                chk("alu_quiet_resp", {alu_a, alu_b, alu_opcode}, 0);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 2'b00);
                end else begin
                    e = exp_q[0];
                    chk("rsp_port", rsp_valid, (e.port == 1) ? 2'b10 : 2'b01);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_z", rsp_z, e.z);
                    chk("rsp_err", rsp_err, e.err);
                    if (!in_rsp) begin
                        chk("rsp_latency", cyc - e.hs, e.div0 ? 1 : e.lat + 1);
                        chk("exec_cycles", exec_n, e.div0 ? 0 : e.lat);
                        in_rsp = 1'b1;
                    end
                    if (rsp_ready[e.port]) begin
                        last_srv = e.port[0];
                        void'(exp_q.pop_front());
                        in_rsp = 1'b0;
                        exec_n = 0;
                    end
                end
            end else if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("exec_unexpected", busy, 1'b0);
                end else begin
                    chk("alu_a_exec", alu_a, exp_q[0].a);
                    chk("alu_b_exec", alu_b, exp_q[0].b);
                    chk("alu_op_exec", alu_opcode, exp_q[0].op);
                end
                exec_n++;
            end else begin
                chk("alu_quiet_idle", {alu_a, alu_b, alu_opcode}, 0);
            end
        end

        if (done) begin
            chk("queue_drained", exp_q.size(), 0);
            chk("driver_timeouts", drv_tmo[0] + drv_tmo[1] + idle_tmo, 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 just after the handshake edge, valid still high.
    task automatic issue(input int p, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int t;
        a_d[p]  = a;
        b_d[p]  = b;
        op_d[p] = op;
        v_d[p]  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[p] && t < 400);
        if (!req_ready[p]) drv_tmo[p]++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 300);
        if (busy) idle_tmo++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int p);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid[p] && t < 50);
        if (!rsp_valid[p]) idle_tmo++;
    endtask

    task automatic rand_port(input int p, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            int           gap;
            logic [2:0]   op;
            logic [N-1:0] a, b;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                v_d[p] = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            b  = N'($urandom);
            if (op == OP_DIV) b = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, 300));
            if (op == OP_SHL || op == OP_SHR) b = N'($urandom_range(0, 24));
            issue(p, op, a, b);
        end
        v_d[p] = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            a_d[p] = '0; b_d[p] = '0; op_d[p] = 3'd0; v_d[p] = 1'b0; drv_tmo[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrapping add to zero on port 0.
        issue(0, OP_ADD, 20'h80000, 20'h80000);
        v_d[0] = 1'b0;
        wait_idle();

        // Divide on port 1 with the response held off for three extra cycles.
        rr_val = 2'b00;
        issue(1, OP_DIV, 20'd6, 20'd4);
        v_d[1] = 1'b0;
        wait_rsp(1);
        repeat (3) @(posedge clk);
        #1 rr_val = 2'b11;
        wait_idle();

        // Both ports continuously valid: grants must alternate.
        fork
            begin
                for (int i = 0; i < 4; i++) issue(0, OP_SUB, 20'hAAAAA, 20'h55555);
                v_d[0] = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++) issue(1, OP_SUB, 20'hAAAAA, 20'h55555);
                v_d[1] = 1'b0;
            end
        join
        wait_idle();

        // Multiply with request-side operands wiggled during execution.
        issue(0, OP_MUL, 20'd6, 20'd2);
        v_d[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_d[1] = N'($urandom);
            a_d[0] = N'($urandom);
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Reset in the middle of a divide, then a contested restart (port 0 must win).
        issue(0, OP_DIV, 20'd100, 20'd7);
        v_d[0] = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            begin issue(0, OP_OR, 20'hAAAAA, 20'h55555); v_d[0] = 1'b0; end
            begin issue(1, OP_AND, 20'hF0F0F, 20'h0FFFF); v_d[1] = 1'b0; end
        join
        wait_idle();

        // Divide by zero on port 1.
        issue(1, OP_DIV, 20'd9, 20'd0);
        v_d[1] = 1'b0;
        wait_idle();

        // Random traffic on both ports with random response backpressure.
        rr_force = 1'b0;
        fork
            rand_port(0, 120);
            rand_port(1, 120);
        join
        rr_force = 1'b1;
        rr_val   = 2'b11;
        wait_idle();
        done = 1'b1;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance (N-bit A/B, 3-bit Opcode, Result, Z) between two requesters: the core datapath (port 0) and the vector/auxiliary unit (port 1).
- Arbitrates with round-robin fairness and holds operands stable for a per-opcode cycle budget, so the slow MUL/DIV paths meet timing as multicycle paths.
- Registers the result and returns it on a per-requester valid/ready response channel.
- Sits between the requesters and the `alu` instance; the `alu` instance is unchanged.

Parameters:
- N, 20, datapath width (matches `alu` N).
- MUL_CYCLES, 2, cycles operands are held for opcode 3'b010 (min 1).
- DIV_CYCLES, 4, cycles operands are held for opcode 3'b011 (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester request accept.
- req_a  in  2*N  operand A, requester i at bits [i*N +: N].
- req_b  in  2*N  operand B, same packing as req_a.
- req_op  in  2*3  opcode, requester i at [i*3 +: 3].
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  N  registered result, shared by both requesters, qualified by rsp_valid.
- rsp_z  out  1  registered zero flag.
- rsp_err  out  1  error flag (see Optional Feature).
- alu_a  out  N  to `alu` A.
- alu_b  out  N  to `alu` B.
- alu_opcode  out  3  to `alu` Opcode.
- alu_result  in  N  from `alu` Result.
- alu_z  in  1  from `alu` Z.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n asynchronous, active-low.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins first contest), count=0.
  - Operand and response registers 0; all outputs 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant g = requester with req_valid; if both are valid, g = ~last_grant.
  - req_ready[g]=1 combinationally from req_valid; the other bit is 0. req_ready is 0 in all other states.
  - On the handshake, capture a/b/op for g into operand registers and load count = lat(op)-1; next state EXEC.
- Latency per opcode:
  - lat = MUL_CYCLES for opcode 010, DIV_CYCLES for 011, otherwise 1.
  - Opcode map: 000 add, 001 sub, 100 and, 101 or, 110 shl, 111 shr.
- EXEC:
  - alu_a/alu_b/alu_opcode are driven from the operand registers and stay stable for the whole state.
  - If count != 0, decrement count.
  - If count == 0, register alu_result and alu_z into rsp_result and rsp_z; next state RESP.
- RESP:
  - rsp_valid[g]=1; rsp_result, rsp_z and rsp_err are held.
  - On rsp_ready[g], drop rsp_valid, set last_grant=g, next state IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Outside EXEC: alu_a/alu_b/alu_opcode are driven 0.
- Throughput: no new grant in the RESP cycle. Minimum occupancy for a 1-cycle op with rsp_ready tied high is 3 cycles, handshake to handshake.
- Result width: N bits, as produced by `alu` (wrap on add/mul, truncation on shl). No widening.
- Request changes while not ready are ignored. Captured operands are immune to later req_* changes.
- Reset mid-operation: abort immediately to the reset values. No response is issued for the in-flight request.
- Starvation bound: a continuously valid requester is granted within one transaction of the other.

Optional Feature:
- Macro: ALU_SHARE_DIV0_EN.
- Defined:
  - An opcode 011 with captured B==0 skips EXEC and goes directly IDLE->RESP.
  - rsp_result = all ones, rsp_z=0, rsp_err=1.
  - The ALU outputs stay 0.
- Undefined:
  - Division by zero goes through the ALU like any division, and the ALU's result is returned as is.
  - rsp_err is tied to 0.

Test Plan:
- Single ADD on port 0: A=20'h80000, B=20'h80000, op 000. Response on port 0 two cycles after handshake; result 20'h00000, z=1, busy high throughout.
- DIV on port 1, DIV_CYCLES=4: A=6, B=4. alu_* stable for 4 cycles; result 20'h00001, z=0; rsp_valid held 3 extra cycles until rsp_ready is asserted.
- Both valid continuously with SUB 20'hAAAAA-20'h55555 on each port. Grants alternate 0,1,0,1; each result is 20'h55555.
- MUL with MUL_CYCLES=2: A=6, B=2. Result 20'h0000C. Port-1 req_a is changed during EXEC and has no effect.
- Reset asserted during EXEC of a DIV. All outputs 0 immediately; after release, a port-0 OR of 20'hAAAAA|20'h55555 returns 20'hFFFFF, z=0.
- DIV with B=0. With ALU_SHARE_DIV0_EN: result 20'hFFFFF, err=1, response 1 cycle after handshake. Without it: err=0 and the ALU's value is returned.
